// File: rtl/ucie_clkpat_pkg.sv
// Shared definitions for the UCIe clock/track pattern generator and its far-end detector.
package ucie_clkpat_pkg;

    localparam int unsigned PATTERN_LENGTH = 48;
    localparam int unsigned TOGGLE_UI      = 32;
    localparam int unsigned BIT_CNT_W      = 6;

    // One iteration sent LSB first: 16 clock periods (1,0,...) then 16 UI low.
    localparam logic [PATTERN_LENGTH-1:0] CLK_PATTERN = 48'h0000_5555_5555;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } clkpat_state_e;

    function automatic logic pattern_bit_at(input logic [BIT_CNT_W-1:0] b);
        return (b < BIT_CNT_W'(TOGGLE_UI)) ? ~b[0] : 1'b0;
    endfunction

endpackage

// File: rtl/ucie_clkpat_bit_sequencer.sv
// Bit/iteration counters for the clock pattern; presents the bit to be shown after the next edge.
module ucie_clkpat_bit_sequencer
    import ucie_clkpat_pkg::*;
#(
    parameter int unsigned ITERATIONS = 128,
    parameter int unsigned ITER_W     = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic advance,
    output logic pattern_bit,
    output logic last_bit
);

    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt_n;
    logic [ITER_W-1:0]    iter_cnt;
    logic                 wrap_c;

    assign wrap_c   = (bit_cnt == BIT_CNT_W'(PATTERN_LENGTH - 1));
    assign last_bit = wrap_c && (iter_cnt == ITER_W'(ITERATIONS - 1));

    // Index of the bit that the lanes will carry after the coming edge.
    always_comb begin
        bit_cnt_n = bit_cnt;
        if (clear) begin
            bit_cnt_n = '0;
        end else if (advance) begin
            bit_cnt_n = wrap_c ? '0 : bit_cnt + BIT_CNT_W'(1);
        end
    end

    assign pattern_bit = pattern_bit_at(bit_cnt_n);

    // Iteration count saturates so continuous bursts never wrap it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bit_cnt  <= '0;
            iter_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt_n;
            if (clear) begin
                iter_cnt <= '0;
            end else if (advance && wrap_c && (iter_cnt != {ITER_W{1'b1}})) begin
                iter_cnt <= iter_cnt + ITER_W'(1);
            end
        end
    end

endmodule

// File: rtl/ucie_clock_pattern_generator.sv
// Mainband clock/track pattern generator for UCIe clock training.
// Optional UCIE_CLKPAT_CONTINUOUS_EN adds i_continuous for bursts that run until i_stop.
module ucie_clock_pattern_generator
    import ucie_clkpat_pkg::*;
#(
    parameter int unsigned ITERATIONS = 128,
    parameter int unsigned ITER_W     = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_stop,
    input  logic i_enable_CKP,
    input  logic i_enable_CKN,
    input  logic i_enable_TRK,
`ifdef UCIE_CLKPAT_CONTINUOUS_EN
    input  logic i_continuous,
`endif
    output logic TCKP_L,
    output logic TCKN_L,
    output logic TTRK_L,
    output logic o_busy,
    output logic o_done
);

    clkpat_state_e state;
    clkpat_state_e state_n;

    logic clear_c;
    logic advance_c;
    logic end_c;
    logic pattern_bit;
    logic last_bit;

    logic ckp_n;
    logic ckn_n;
    logic trk_n;
    logic busy_n;
    logic done_n;

    ucie_clkpat_bit_sequencer #(
        .ITERATIONS (ITERATIONS),
        .ITER_W     (ITER_W)
    ) u_seq (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .clear       (clear_c),
        .advance     (advance_c),
        .pattern_bit (pattern_bit),
        .last_bit    (last_bit)
    );

`ifdef UCIE_CLKPAT_CONTINUOUS_EN
    logic continuous_q;

    // Mode is captured at burst start so mid-burst changes cannot truncate it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            continuous_q <= 1'b0;
        end else if (clear_c) begin
            continuous_q <= i_continuous;
        end
    end

    assign end_c = last_bit && !continuous_q;
`else
    assign end_c = last_bit;
`endif

    assign clear_c   = (state == ST_IDLE) && i_start;
    assign advance_c = (state == ST_BURST) && !i_stop && !end_c;

    // Next state and next registered outputs; lanes only carry pattern while bursting.
    always_comb begin
        state_n = state;
        ckp_n   = 1'b0;
        ckn_n   = 1'b0;
        trk_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_n = ST_BURST;
                    busy_n  = 1'b1;
                    ckp_n   = pattern_bit & i_enable_CKP;
                    ckn_n   = pattern_bit & i_enable_CKN;
                    trk_n   = pattern_bit & i_enable_TRK;
                end
            end
            ST_BURST: begin
                if (i_stop || end_c) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else begin
                    busy_n = 1'b1;
                    ckp_n  = pattern_bit & i_enable_CKP;
                    ckn_n  = pattern_bit & i_enable_CKN;
                    trk_n  = pattern_bit & i_enable_TRK;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            TCKP_L <= 1'b0;
            TCKN_L <= 1'b0;
            TTRK_L <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_n;
            TCKP_L <= ckp_n;
            TCKN_L <= ckn_n;
            TTRK_L <= trk_n;
            o_busy <= busy_n;
            o_done <= done_n;
        end
    end

endmodule

// File: tb/tb_ucie_clock_pattern_generator.sv
// Scoreboard bench: driver models the expected outputs per cycle, monitor compares at negedge.
module tb_ucie_clock_pattern_generator;

    localparam int ITER      = 2;
    localparam int BURST_LEN = 48 * ITER;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_start;
    logic i_stop;
    logic i_enable_CKP;
    logic i_enable_CKN;
    logic i_enable_TRK;
`ifdef UCIE_CLKPAT_CONTINUOUS_EN
    logic i_continuous = 1'b0;
`endif
    logic TCKP_L;
    logic TCKN_L;
    logic TTRK_L;
    logic o_busy;
    logic o_done;

    int checks   = 0;
    int errors   = 0;
    int cycle    = 0;
    int done_cnt = 0;
    int busy_run = 0;

    logic [4:0] exp_q[$];

    // Reference: 0 idle, 1 bursting at stream position m_pos, 2 done cycle.
    int m_phase = 0;
    int m_pos   = 0;

    always #5 i_clk = ~i_clk;

    ucie_clock_pattern_generator #(
        .ITERATIONS (ITER),
        .ITER_W     (8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_enable_CKP (i_enable_CKP),
        .i_enable_CKN (i_enable_CKN),
        .i_enable_TRK (i_enable_TRK),
`ifdef UCIE_CLKPAT_CONTINUOUS_EN
        .i_continuous (i_continuous),
`endif
        .TCKP_L       (TCKP_L),
        .TCKN_L       (TCKN_L),
        .TTRK_L       (TTRK_L),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // Bit at stream position p: 16 clock periods starting high, then 16 UI low.
    function automatic logic ref_bit(input int p);
        int u;
        u = p % 48;
        return (u < 32) && ((u % 2) == 0);
    endfunction

    // Apply one cycle of inputs and push the outputs expected after the next edge.
    task automatic step(input logic rst, input logic st, input logic sp,
                        input logic ep, input logic en, input logic et);
        logic b;
        logic [4:0] e;
        i_rst_n = rst; i_start = st; i_stop = sp;
        i_enable_CKP = ep; i_enable_CKN = en; i_enable_TRK = et;
        e = 5'b0;
        if (!rst) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (st) begin
                m_phase = 1;
                m_pos   = 0;
                b = ref_bit(0);
                e = {b & ep, b & en, b & et, 1'b1, 1'b0};
            end
        end else if (m_phase == 1) begin
            if (sp || (m_pos == BURST_LEN - 1)) begin
                m_phase = 2;
                e = 5'b00001;
            end else begin
                m_pos = m_pos + 1;
                b = ref_bit(m_pos);
                e = {b & ep, b & en, b & et, 1'b1, 1'b0};
            end
        end else begin
            m_phase = 0;
        end
        exp_q.push_back(e);
        @(negedge i_clk);
        #1;
    endtask

    task automatic idle_n(input int n, input logic en_ckn);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b1, en_ckn, 1'b1);
    endtask

    initial begin : monitor
        logic [4:0] got;
        logic [4:0] e;
        forever begin
            @(negedge i_clk);
            cycle++;
            if (o_done === 1'b1) done_cnt++;
            busy_run = (o_busy === 1'b1) ? busy_run + 1 : 0;
            if (busy_run > BURST_LEN) begin
                errors++;
                $display("FAIL busy watchdog cycle %0d: o_busy high for %0d cycles (max %0d)",
                         cycle, busy_run, BURST_LEN);
            end
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {TCKP_L, TCKN_L, TTRK_L, o_busy, o_done};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d {ckp,ckn,trk,busy,done} got %b expected %b",
                             cycle, got, e);
                end
            end
        end
    end

    initial begin : driver
        logic ep, en, et, st, sp, rst;
        int done_before;
        // reset
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({TCKP_L, TCKN_L, TTRK_L, o_busy, o_done} !== 5'b00000) begin
            errors++;
            $display("FAIL reset state {ckp,ckn,trk,busy,done} got %b expected 00000",
                     {TCKP_L, TCKN_L, TTRK_L, o_busy, o_done});
        end
        idle_n(2, 1'b1);
        // full burst, all lanes; o_done must arrive within the burst window
        done_before = done_cnt;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_n(BURST_LEN + 4, 1'b1);
        checks++;
        if (done_cnt != done_before + 1) begin
            errors++;
            $display("FAIL timeout waiting for o_done: %0d pulses in %0d cycles, expected 1",
                     done_cnt - done_before, BURST_LEN + 5);
        end
        // CKN lane disabled
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_n(BURST_LEN + 4, 1'b0);
        // abort at burst cycle 50, then restart from bit 0
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_n(49, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_n(3, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_n(BURST_LEN + 4, 1'b1);
        // start re-pulsed mid-burst at cycles 10 and 47 is ignored
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < BURST_LEN + 4; i++)
            step(1'b1, (i == 10) || (i == 47), 1'b0, 1'b1, 1'b1, 1'b1);
        // start and stop together in IDLE starts a burst; stop then aborts it
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_n(5, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_n(3, 1'b1);
        // reset at burst cycle 20, then a fresh burst
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_n(19, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_n(2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_n(BURST_LEN + 4, 1'b1);
        // randomized traffic with mid-burst enable changes
        ep = 1'b1; en = 1'b1; et = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) ep = ~ep;
            if ($urandom_range(15) == 0) en = ~en;
            if ($urandom_range(15) == 0) et = ~et;
            st  = ($urandom_range(7) == 0);
            sp  = ($urandom_range(149) == 0);
            rst = ($urandom_range(1499) != 0);
            step(rst, st, sp, ep, en, et);
        end
        idle_n(2, 1'b1);
        @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
